// File: rtl/time_pkg.sv
// Shared constants, field encoding and BCD step helpers for the timekeeper.
package time_pkg;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] BCD_ZERO = 8'h00;

  // Which field the up/down buttons edit in set mode
  typedef enum logic {
    FIELD_HOUR = 1'b0,
    FIELD_MIN  = 1'b1
  } field_e;

  // Two-digit BCD increment, wrapping from max back to 00
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] res;
    if (v == max) begin
      res = BCD_ZERO;
    end else if (v[3:0] == 4'd9) begin
      res = {v[7:4] + 4'd1, 4'd0};
    end else begin
      res = {v[7:4], v[3:0] + 4'd1};
    end
    return res;
  endfunction

  // Two-digit BCD decrement, wrapping from 00 up to max
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    logic [7:0] res;
    if (v == BCD_ZERO) begin
      res = max;
    end else if (v[3:0] == 4'd0) begin
      res = {v[7:4] - 4'd1, 4'd9};
    end else begin
      res = {v[7:4], v[3:0] - 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD up/down counter wrapping at MAX, with synchronous clear.
module bcd2_counter
  import time_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       inc,
  input  logic       dec,
  input  logic       clr,
  output logic [7:0] value,
  output logic       carry,
  output logic       borrow
);

  logic [7:0] r_value;
  logic       w_do_inc;
  logic       w_do_dec;

  // Simultaneous inc and dec cancel; clear wins over both
  assign w_do_inc = inc & ~dec & ~clr;
  assign w_do_dec = dec & ~inc & ~clr;

  assign value  = r_value;
  assign carry  = w_do_inc & (r_value == MAX);
  assign borrow = w_do_dec & (r_value == BCD_ZERO);

  // Counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_value <= BCD_ZERO;
    end else if (clr) begin
      r_value <= BCD_ZERO;
    end else if (w_do_inc) begin
      r_value <= bcd_inc(r_value, MAX);
    end else if (w_do_dec) begin
      r_value <= bcd_dec(r_value, MAX);
    end
  end

endmodule

// File: rtl/time_keeper.sv
// 24 h HH:MM:SS timekeeper with 1 Hz prescaler, button-driven set mode
// and one-cycle second/minute strobes.
module time_keeper
  import time_pkg::*;
#(
  parameter int CLK_HZ  = 100000000,
  parameter int PRESC_W = 27
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        set_en,
  input  logic        push_u,
  input  logic        push_d,
  input  logic        push_l,
  input  logic        push_r,
  output logic [15:0] current,
  output logic [7:0]  seconds,
  output logic        field_sel,
  output logic        sec_tick,
  output logic        min_tick
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

  // Button bit order: {r, l, d, u}
  localparam int B_U = 0;
  localparam int B_D = 1;
  localparam int B_L = 2;
  localparam int B_R = 3;

  logic [PRESC_W-1:0] r_presc;
  logic [3:0]         r_sync1;
  logic [3:0]         r_sync2;
  logic [3:0]         r_prev;
  logic               r_set_prev;
  field_e             r_field_sel;
  logic               r_sec_tick;
  logic               r_min_tick;

  logic [3:0] w_push;
  logic [3:0] w_edge;
  logic       w_tick;
  logic       w_exit;
  logic       w_up;
  logic       w_dn;
  logic       w_sel_hour;
  logic       w_sel_min;
  logic [7:0] w_sec;
  logic [7:0] w_min;
  logic [7:0] w_hour;
  logic       w_sec_carry;
  logic       w_min_carry;
  logic       w_hour_carry;
  logic       w_sec_borrow;
  logic       w_min_borrow;
  logic       w_hour_borrow;
  logic       w_unused_flags;

  assign w_push = {push_r, push_l, push_d, push_u};
  assign w_edge = r_sync2 & ~r_prev;

  // A tick only counts in run mode; one landing in a set cycle is dropped
  assign w_tick = ~set_en & (r_presc == PRESC_LAST);
  assign w_exit = ~set_en & r_set_prev;

  // Edits act only in set mode; opposing up/down edges cancel
  assign w_up       = set_en & w_edge[B_U] & ~w_edge[B_D];
  assign w_dn       = set_en & w_edge[B_D] & ~w_edge[B_U];
  assign w_sel_hour = (r_field_sel == FIELD_HOUR);
  assign w_sel_min  = (r_field_sel == FIELD_MIN);

  // Prescaler: held at zero in set mode, wraps at CLK_HZ-1 in run mode
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_presc <= '0;
    end else if (set_en || (r_presc == PRESC_LAST)) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  // Push synchronizers and previous-value flops for rising-edge detect
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= w_push;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Mode tracking, field selection and registered strobes
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_set_prev  <= 1'b0;
      r_field_sel <= FIELD_HOUR;
      r_sec_tick  <= 1'b0;
      r_min_tick  <= 1'b0;
    end else begin
      r_set_prev <= set_en;
      r_sec_tick <= w_tick;
      r_min_tick <= w_tick & w_sec_carry;
      if (set_en) begin
        if (w_edge[B_L] && !w_edge[B_R]) begin
          r_field_sel <= FIELD_HOUR;
        end else if (w_edge[B_R] && !w_edge[B_L]) begin
          r_field_sel <= FIELD_MIN;
        end
      end
    end
  end

  // Seconds clear on leaving set mode so the new time starts on a whole minute
  bcd2_counter #(.MAX(SEC_MAX)) u_sec (
    .clk    (clk),
    .resetn (resetn),
    .inc    (w_tick),
    .dec    (1'b0),
    .clr    (w_exit),
    .value  (w_sec),
    .carry  (w_sec_carry),
    .borrow (w_sec_borrow)
  );

  bcd2_counter #(.MAX(MIN_MAX)) u_min (
    .clk    (clk),
    .resetn (resetn),
    .inc    ((w_tick & w_sec_carry) | (w_up & w_sel_min)),
    .dec    (w_dn & w_sel_min),
    .clr    (1'b0),
    .value  (w_min),
    .carry  (w_min_carry),
    .borrow (w_min_borrow)
  );

  // Minute wrap only carries into hours in run mode; edits never carry
  bcd2_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk    (clk),
    .resetn (resetn),
    .inc    ((w_min_carry & ~set_en) | (w_up & w_sel_hour)),
    .dec    (w_dn & w_sel_hour),
    .clr    (1'b0),
    .value  (w_hour),
    .carry  (w_hour_carry),
    .borrow (w_hour_borrow)
  );

  // Day rollover and borrows have no consumer here
  assign w_unused_flags = w_hour_carry | w_sec_borrow | w_min_borrow | w_hour_borrow;

  assign current   = {w_hour, w_min};
  assign seconds   = w_sec;
  assign field_sel = r_field_sel;
  assign sec_tick  = r_sec_tick;
  assign min_tick  = r_min_tick;

endmodule

// File: tb/tb_time_keeper.sv
// Randomized and directed bench for time_keeper against a time-of-day model.
module tb_time_keeper;

  localparam int CLK_HZ = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        set_en = 1'b0;
  logic [3:0]  btn = 4'b0000;   // {r, l, d, u}
  logic [15:0] current;
  logic [7:0]  seconds;
  logic        field_sel;
  logic        sec_tick;
  logic        min_tick;
  logic [31:0] dut_vec;

  int checks = 0;
  int errors = 0;

  // Model state: plain time of day plus a sample history per button
  int       mh, mm, ms, mpresc;
  bit       mfield, mset_last, msec_tick, mmin_tick;
  bit [2:0] hist [4];
  int       sec_cnt, min_cnt;

  time_keeper #(.CLK_HZ(CLK_HZ), .PRESC_W(3)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .set_en    (set_en),
    .push_u    (btn[0]),
    .push_d    (btn[1]),
    .push_l    (btn[2]),
    .push_r    (btn[3]),
    .current   (current),
    .seconds   (seconds),
    .field_sel (field_sel),
    .sec_tick  (sec_tick),
    .min_tick  (min_tick)
  );

  always #5 clk = ~clk;

  assign dut_vec = {5'd0, current, seconds, field_sel, sec_tick, min_tick};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int x);
    return 8'(((x / 10) * 16) + (x % 10));
  endfunction

  function automatic logic [31:0] model_vec();
    return {5'd0, to_bcd(mh), to_bcd(mm), to_bcd(ms), mfield, msec_tick, mmin_tick};
  endfunction

  task automatic model_reset();
    mh = 0; mm = 0; ms = 0; mpresc = 0;
    mfield = 0; mset_last = 0; msec_tick = 0; mmin_tick = 0;
    for (int b = 0; b < 4; b++) hist[b] = 3'b000;
  endtask

  // One rising edge of the reference behaviour
  task automatic model_edge();
    bit [3:0] e;
    int tod;
    for (int b = 0; b < 4; b++) begin
      e[b] = hist[b][1] & ~hist[b][2];
      hist[b] = {hist[b][1:0], btn[b]};
    end
    msec_tick = 0;
    mmin_tick = 0;
    if (set_en) begin
      mpresc = 0;
      if (e[0] && !e[1]) begin
        if (!mfield) mh = (mh + 1) % 24; else mm = (mm + 1) % 60;
      end else if (e[1] && !e[0]) begin
        if (!mfield) mh = (mh + 23) % 24; else mm = (mm + 59) % 60;
      end
      if (e[2] && !e[3]) mfield = 0;
      else if (e[3] && !e[2]) mfield = 1;
    end else begin
      if (mset_last) ms = 0;
      if (mpresc == CLK_HZ - 1) begin
        msec_tick = 1;
        if (ms == 59) mmin_tick = 1;
        tod = ((mh * 60 + mm) * 60 + ms + 1) % 86400;
        mh = tod / 3600;
        mm = (tod / 60) % 60;
        ms = tod % 60;
      end
      mpresc = (mpresc + 1) % CLK_HZ;
    end
    mset_last = set_en;
  endtask

  // Advance one clock, update the model, compare all outputs
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("cycle", dut_vec, model_vec());
    sec_cnt += int'(sec_tick);
    min_cnt += int'(min_tick);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Called 1 ns after an edge: assert reset between edges, release before next
  task automatic do_reset();
    resetn = 1'b0;
    #2;
    model_reset();
    check("reset", dut_vec, model_vec());
    #2;
    resetn = 1'b1;
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    steps(2);
    btn[b] = 1'b0;
    steps(3);
  endtask

  initial begin
    int n;
    logic [7:0] sec_exp;

    model_reset();
    #3;
    check("reset_init", dut_vec, 32'd0);
    #20 resetn = 1'b1;

    // 1: one minute of run mode from reset
    sec_cnt = 0; min_cnt = 0;
    for (int i = 0; i < 240; i++) begin
      step();
      if (i == 3) check("t1_first_tick", {31'd0, sec_tick}, 32'd1);
    end
    check("t1_sec_ticks", sec_cnt, 60);
    check("t1_min_ticks", min_cnt, 1);
    check("t1_current", {16'd0, current}, 32'h0001);
    check("t1_seconds", {24'd0, seconds}, 32'h00);

    // 2: decrement hours with wrap, minutes wrap, then minute carry into hour
    do_reset();
    set_en = 1'b1;
    step();
    press(1); check("t2_h23", {16'd0, current}, 32'h2300);
    press(1); check("t2_h22", {16'd0, current}, 32'h2200);
    press(1); check("t2_h21", {16'd0, current}, 32'h2100);
    press(3);
    press(1); check("t2_m59", {16'd0, current}, 32'h2159);
    check("t2_field", {31'd0, field_sel}, 32'd1);
    set_en = 1'b0;
    steps(240);
    check("t2_carry", {16'd0, current}, 32'h2200);

    // 3: 23:59 rolls to 00:00
    set_en = 1'b1;
    step();
    press(2); press(0); press(3); press(1);
    check("t3_set", {16'd0, current}, 32'h2359);
    set_en = 1'b0;
    sec_cnt = 0; min_cnt = 0;
    steps(240);
    check("t3_current", {16'd0, current}, 32'h0000);
    check("t3_seconds", {24'd0, seconds}, 32'h00);
    check("t3_min_ticks", min_cnt, 1);

    // 4: held button gives one action after two edges; u+d together cancels
    set_en = 1'b1;
    step();
    btn[0] = 1'b1;
    steps(2);
    check("t4_not_yet", {16'd0, current}, 32'h0000);
    step();
    check("t4_inc", {16'd0, current}, 32'h0001);
    steps(7);
    btn[0] = 1'b0;
    steps(3);
    check("t4_held_once", {16'd0, current}, 32'h0001);
    btn = 4'b0011;
    steps(2);
    btn = 4'b0000;
    steps(3);
    check("t4_ud_cancel", {16'd0, current}, 32'h0001);

    // 5: buttons ignored in run mode; freeze mid-second and restart
    set_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn[0] = 1'b1; step();
      btn[0] = 1'b0; steps(2);
    end
    step();
    check("t5_run_ignore", {16'd0, current}, 32'h0001);
    n = 0;
    while (mpresc != 2 && n < 20) begin step(); n++; end
    check("t5_presc_found", {31'd0, mpresc == 2}, 32'd1);
    sec_exp = to_bcd(ms);
    set_en = 1'b1;
    steps(9);
    check("t5_frozen", {24'd0, seconds}, {24'd0, sec_exp});
    set_en = 1'b0;
    step();
    check("t5_sec_clr", {24'd0, seconds}, 32'h00);
    n = 1;
    while (!sec_tick && n < 20) begin step(); n++; end
    check("t5_tick_latency", n, 4);

    // 6: async reset at 13:47:30, then first tick latency from release
    set_en = 1'b1;
    step();
    press(2);
    n = 0;
    while (mh != 13 && n < 30) begin press(0); n++; end
    press(3);
    n = 0;
    while (mm != 47 && n < 70) begin press(0); n++; end
    set_en = 1'b0;
    n = 0;
    while (!(ms == 30 && mpresc == 1) && n < 300) begin step(); n++; end
    check("t6_time", {8'd0, current, seconds}, 32'h0013_4730);
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    check("t6_async_rst", dut_vec, 32'd0);
    #3 resetn = 1'b1;
    n = 0;
    sec_cnt = 0;
    while (sec_cnt == 0 && n < 20) begin step(); n++; end
    check("t6_tick_latency", n, 4);

    // Random phase: random buttons, mode changes and occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) set_en = ~set_en;
      if ($urandom_range(0, 2) == 0) btn = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
